// File: rtl/eth_txbackoff_sched_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet transmit
// backoff scheduler. Optional feature macro: ETH_BACKOFF_LFSR_EN.
package eth_txbackoff_sched_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } bkState_t;

    // One backoff slot is 128 nibble times on the MII transmit clock
    localparam int SLOT_NIBBLES  = 128;
    localparam int SLOT_SHIFT    = $clog2(SLOT_NIBBLES);

    // Backoff exponent saturates at 10 (truncated binary exponential backoff)
    localparam int BACKOFF_LIMIT = 10;

    // Random source width, wait counter width (1023 * 128 = 130944 < 2**17)
    localparam int RND_W  = 10;
    localparam int WAIT_W = 17;
    localparam int CNT_W  = 4;

    // Fixed worst-case random value used when no LFSR is built in
    localparam logic [RND_W-1:0] RND_FIXED = 10'h3FF;

    // LFSR seed after reset
    localparam logic [RND_W-1:0] LFSR_SEED = 10'h001;

    // Mask of the low min(retries, BACKOFF_LIMIT) bits of the random value
    function automatic logic [RND_W-1:0] slotMask(input logic [CNT_W-1:0] retries);
        logic [CNT_W-1:0] k;
        logic [RND_W:0]   m;
        k = (retries > CNT_W'(BACKOFF_LIMIT)) ? CNT_W'(BACKOFF_LIMIT) : retries;
        m = ((RND_W+1)'(1) << k) - (RND_W+1)'(1);
        return m[RND_W-1:0];
    endfunction

endpackage

// File: rtl/eth_txbackoff_sched_if.sv
// Bundle of the backoff scheduler's control and status signals, so the
// transmit state machine and its environment can pass them around as one.
// Optional feature macro: ETH_BACKOFF_LFSR_EN.
interface eth_txbackoff_sched_if
    import eth_txbackoff_sched_pkg::*;
(
    input logic MTxClk
);
    logic               StartBackoff;
    logic               TxDone;
    logic               TxAbort;
    logic               NoBckof;
    logic [CNT_W-1:0]   MaxRet;
    logic               BackoffActive;
    logic               BackoffDone;
    logic               RetryLimit;
    logic [CNT_W-1:0]   RetryCnt;
    logic [RND_W-1:0]   RandomSlots;

    // Transmit controller side: raises requests, watches backoff status
    modport master (
        input  MTxClk,
        output StartBackoff, TxDone, TxAbort, NoBckof, MaxRet,
        input  BackoffActive, BackoffDone, RetryLimit, RetryCnt, RandomSlots
    );

    // Scheduler side: consumes requests, reports backoff status
    modport slave (
        input  MTxClk,
        input  StartBackoff, TxDone, TxAbort, NoBckof, MaxRet,
        output BackoffActive, BackoffDone, RetryLimit, RetryCnt, RandomSlots
    );

endinterface

// File: rtl/eth_txbackoff_sched_lfsr.sv
// Free-running 10-bit LFSR (x^10 + x^7 + 1) used as the backoff random source.
// Only compiled when ETH_BACKOFF_LFSR_EN is defined.
`ifdef ETH_BACKOFF_LFSR_EN
module eth_backoff_lfsr
    import eth_txbackoff_sched_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [RND_W-1:0] o_rnd
);

    logic [RND_W-1:0] r_lfsr;
    logic             w_feedback;

    assign w_feedback = r_lfsr[9] ^ r_lfsr[6];

    // Shift every clock; the seed is non-zero so the sequence never locks up
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[RND_W-2:0], w_feedback};
        end
    end

    assign o_rnd = r_lfsr;

endmodule
`endif

// File: rtl/eth_txbackoff_sched.sv
// Ethernet transmit backoff scheduler: counts collisions for the current
// frame, picks a random slot count after each collision and times the wait
// before the frame may be retried, or reports that the retry limit was hit.
// Optional feature macro: ETH_BACKOFF_LFSR_EN (random slots from an LFSR;
// otherwise every backoff uses the worst-case all-ones random value).
module eth_txbackoff_sched
    import eth_txbackoff_sched_pkg::*;
#(
    // Accepted for drop-in compatibility with the rest of the MAC; it has no
    // effect on the synthesized behaviour.
    parameter int Tp = 1
)
(
    input  logic             MTxClk,
    input  logic             Reset,
    input  logic             StartBackoff,
    input  logic             TxDone,
    input  logic             TxAbort,
    input  logic             NoBckof,
    input  logic [CNT_W-1:0] MaxRet,
    output logic             BackoffActive,
    output logic             BackoffDone,
    output logic             RetryLimit,
    output logic [CNT_W-1:0] RetryCnt,
    output logic [RND_W-1:0] RandomSlots
);

    bkState_t          r_state;
    bkState_t          w_stateNext;
    logic [CNT_W-1:0]  r_retryCnt;
    logic              r_retryLimit;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [RND_W-1:0]  r_randomSlots;

    logic [RND_W-1:0]  w_rnd;
    logic [RND_W-1:0]  w_slots;
    logic [WAIT_W-1:0] w_waitLoad;
    logic [CNT_W:0]    w_retryNext;
    logic              w_limitHit;
    logic              w_startRetry;
    logic              w_hitLimit;
    logic              w_load;
    logic              w_done;

`ifdef ETH_BACKOFF_LFSR_EN
    eth_backoff_lfsr u_lfsr (
        .i_clk (MTxClk),
        .i_rst (Reset),
        .o_rnd (w_rnd)
    );
`else
    assign w_rnd = RND_FIXED;
`endif

    // Slot count uses the already-incremented retry count, so the first
    // collision draws from {0,1}, the second from {0..3}, and so on
    assign w_slots    = w_rnd & slotMask(r_retryCnt);
    assign w_waitLoad = NoBckof ? '0 : (WAIT_W'(w_slots) << SLOT_SHIFT);

    // One extra bit so RetryCnt+1 compares correctly against MaxRet=15
    assign w_retryNext = {1'b0, r_retryCnt} + (CNT_W+1)'(1);
    assign w_limitHit  = (w_retryNext >= {1'b0, MaxRet});

    // State register
    always_ff @(posedge MTxClk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode; abort beats completion of the wait in the same cycle
    always_comb begin
        w_stateNext  = r_state;
        w_startRetry = 1'b0;
        w_hitLimit   = 1'b0;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (StartBackoff) begin
                    if (w_limitHit) begin
                        w_hitLimit = 1'b1;
                    end else begin
                        w_startRetry = 1'b1;
                        w_stateNext  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (TxAbort) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (TxAbort) begin
                    w_stateNext = ST_IDLE;
                end else if (r_waitCnt == '0) begin
                    w_done      = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Collision counter and retry-limit pulse; a new collision outranks a
    // frame completion arriving in the same cycle
    always_ff @(posedge MTxClk or posedge Reset) begin
        if (Reset) begin
            r_retryCnt   <= '0;
            r_retryLimit <= 1'b0;
        end else begin
            r_retryLimit <= w_hitLimit;
            if (w_startRetry) begin
                r_retryCnt <= r_retryCnt + CNT_W'(1);
            end else if (w_hitLimit || TxDone || TxAbort) begin
                r_retryCnt <= '0;
            end
        end
    end

    // Wait timer and latched slot count; an abort parks the timer at zero
    always_ff @(posedge MTxClk or posedge Reset) begin
        if (Reset) begin
            r_waitCnt     <= '0;
            r_randomSlots <= '0;
        end else begin
            if (w_load) begin
                r_waitCnt     <= w_waitLoad;
                r_randomSlots <= w_slots;
            end else if (r_state == ST_WAIT) begin
                if (TxAbort) begin
                    r_waitCnt <= '0;
                end else if (r_waitCnt != '0) begin
                    r_waitCnt <= r_waitCnt - WAIT_W'(1);
                end
            end
        end
    end

    assign BackoffActive = (r_state == ST_LOAD) || (r_state == ST_WAIT);
    assign BackoffDone   = w_done;
    assign RetryLimit    = r_retryLimit;
    assign RetryCnt      = r_retryCnt;
    assign RandomSlots   = r_randomSlots;

endmodule
